// File: rtl/imem_dmem_arbiter.sv
// Two-requester arbiter that shares one req/gnt/rvalid memory port between fetch and the LSU.
// Data wins by default; fetch is forced through after STARVE_LIMIT lost cycles. Responses are routed in order via an ID FIFO.
module imem_dmem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    input  logic        instr_flush_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    owner_e             fifo_id   [MAX_OUTSTANDING];
    logic               fifo_drop [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               lock_q;
    owner_e             lock_owner_q;
    logic [STV_W-1:0]   starve_cnt;

    logic   sel_valid;
    owner_e sel_owner;
    logic   fifo_full;
    logic   fifo_empty;
    logic   handshake;
    logic   pop;
    owner_e head_id;
    logic   head_drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_valid = 1'b0;
        sel_owner = OWN_DATA;
        if (lock_q) begin
            sel_valid = 1'b1;
            sel_owner = lock_owner_q;
        end else if (starve_cnt == STV_W'(STARVE_LIMIT) && instr_req_i) begin
            sel_valid = 1'b1;
            sel_owner = OWN_INSTR;
        end else if (data_req_i) begin
            sel_valid = 1'b1;
            sel_owner = OWN_DATA;
        end else if (instr_req_i) begin
            sel_valid = 1'b1;
            sel_owner = OWN_INSTR;
        end
    end

    // Full is taken from registered occupancy only; a same-cycle pop does not free a slot.
    assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);

    assign mem_req_o   = rstn & sel_valid & ~fifo_full;
    assign handshake   = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = handshake & (sel_owner == OWN_INSTR);
    assign data_gnt_o  = handshake & (sel_owner == OWN_DATA);

    assign mem_we_o    = (sel_owner == OWN_DATA) ? data_we_i    : 1'b0;
    assign mem_be_o    = (sel_owner == OWN_DATA) ? data_be_i    : 4'hF;
    assign mem_addr_o  = (sel_owner == OWN_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = (sel_owner == OWN_DATA) ? data_wdata_i : 32'h0;

    assign head_id   = fifo_id[rd_ptr];
    assign head_drop = fifo_drop[rd_ptr];
    assign pop       = mem_rvalid_i & ~fifo_empty;

    assign instr_rvalid_o = pop & (head_id == OWN_INSTR) & ~head_drop;
    assign data_rvalid_o  = pop & (head_id == OWN_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    // NOTE: sequential state is updated with non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_INSTR;
            starve_cnt   <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_id[i]   <= OWN_INSTR;
                fifo_drop[i] <= 1'b0;
            end
        end else begin
            if (handshake) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)       rd_ptr <= ptr_inc(rd_ptr);

            case ({handshake, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // A flush marks queued fetches; the push below overrides its own slot with the same rule.
            if (instr_flush_i) begin
                for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                    if (fifo_id[i] == OWN_INSTR) fifo_drop[i] <= 1'b1;
                end
            end
            if (handshake) begin
                fifo_id[wr_ptr]   <= sel_owner;
                fifo_drop[wr_ptr] <= (sel_owner == OWN_INSTR) & instr_flush_i;
            end

            if (mem_req_o && !mem_gnt_i) begin
                lock_q       <= 1'b1;
                lock_owner_q <= sel_owner;
            end else if (handshake) begin
                lock_q <= 1'b0;
            end

            if (instr_req_i && !instr_gnt_o) begin
                if (starve_cnt != STV_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + STV_W'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end

`ifndef SYNTHESIS
    a_rvalid_with_outstanding: assert property (@(posedge clk) disable iff (!rstn)
        mem_rvalid_i |-> !fifo_empty);
    a_instr_stable_while_locked: assert property (@(posedge clk) disable iff (!rstn)
        (lock_q && lock_owner_q == OWN_INSTR) |-> $stable(instr_addr_i));
    a_data_stable_while_locked: assert property (@(posedge clk) disable iff (!rstn)
        (lock_q && lock_owner_q == OWN_DATA) |->
            $stable({data_we_i, data_be_i, data_addr_i, data_wdata_i}));
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: a per-cycle vector table plus hand sequences
// for starvation, flush, full-FIFO and reset-mid-transaction behaviour.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        instr_req_i, instr_flush_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] WDATA = 32'hDEADBEEF;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rstn(rstn),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_flush_i(instr_flush_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    typedef struct packed {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_mreq;
        logic [31:0] e_maddr;
        logic        e_mwe;
        logic [3:0]  e_mbe;
        logic [31:0] e_mwdata;
        logic        e_igs;
        logic        e_dgnt;
        logic        e_irv;
        logic        e_drv;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NVEC = 16;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic iflush,
                         input logic dreq, input logic dwe, input logic [31:0] daddr,
                         input logic gnt, input logic rv, input logic [31:0] rdata, input logic err);
        @(negedge clk);
        instr_req_i   = ireq;
        instr_addr_i  = iaddr;
        instr_flush_i = iflush;
        data_req_i    = dreq;
        data_we_i     = dwe;
        data_addr_i   = daddr;
        mem_gnt_i     = gnt;
        mem_rvalid_i  = rv;
        mem_rdata_i   = rdata;
        mem_err_i     = err;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        data_be_i    = 4'hC;
        data_wdata_i = WDATA;

        // Reset state, with requests and gnt present to show they are masked.
        drive(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0);
        check("reset mem_req", mem_req_o, 0);
        check("reset instr_gnt", instr_gnt_o, 0);
        check("reset data_gnt", data_gnt_o, 0);
        check("reset instr_rvalid", instr_rvalid_o, 0);
        check("reset data_rvalid", data_rvalid_o, 0);
        idle();
        rstn = 1'b1;

        //          ireq  iaddr         dreq  dwe   daddr         gnt   rv    rdata      | mreq  maddr         mwe   mbe   mwdata        igs   dgnt  irv   drv   erdata
        tbl[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,       1'b1, 32'h100,      1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h200,      1'b1, 1'b0, 32'h0,       1'b1, 32'h200,      1'b0, 4'hC, WDATA,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'h104,      1'b1, 1'b1, 32'h204,      1'b1, 1'b1, 32'h11,      1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h11};
        tbl[4]  = '{1'b1, 32'h104,      1'b1, 1'b1, 32'h204,      1'b1, 1'b1, 32'h22,      1'b1, 32'h204,      1'b1, 4'hC, WDATA,        1'b0, 1'b1, 1'b0, 1'b1, 32'h22};
        tbl[5]  = '{1'b1, 32'h104,      1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,       1'b1, 32'h104,      1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h33,      1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h33};
        tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h44,      1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h44};
        tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 32'h180,      1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       1'b1, 32'h180,      1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 32'h180,      1'b1, 1'b0, 32'h280,      1'b0, 1'b0, 32'h0,       1'b1, 32'h180,      1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 32'h180,      1'b1, 1'b0, 32'h280,      1'b0, 1'b0, 32'h0,       1'b1, 32'h180,      1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 32'h180,      1'b1, 1'b0, 32'h280,      1'b1, 1'b0, 32'h0,       1'b1, 32'h180,      1'b0, 4'hF, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h280,      1'b1, 1'b0, 32'h0,       1'b1, 32'h280,      1'b0, 4'hC, WDATA,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h55,      1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h55};
        tbl[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h66,      1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h66};

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].ireq, tbl[i].iaddr, 1'b0, tbl[i].dreq, tbl[i].dwe, tbl[i].daddr,
                  tbl[i].gnt, tbl[i].rv, tbl[i].rdata, 1'b0);
            check($sformatf("row%0d mem_req", i), mem_req_o, tbl[i].e_mreq);
            if (tbl[i].e_mreq) begin
                check($sformatf("row%0d mem_addr", i), mem_addr_o, tbl[i].e_maddr);
                check($sformatf("row%0d mem_we", i), mem_we_o, tbl[i].e_mwe);
                check($sformatf("row%0d mem_be", i), mem_be_o, tbl[i].e_mbe);
                check($sformatf("row%0d mem_wdata", i), mem_wdata_o, tbl[i].e_mwdata);
            end
            check($sformatf("row%0d instr_gnt", i), instr_gnt_o, tbl[i].e_igs);
            check($sformatf("row%0d data_gnt", i), data_gnt_o, tbl[i].e_dgnt);
            check($sformatf("row%0d instr_rvalid", i), instr_rvalid_o, tbl[i].e_irv);
            check($sformatf("row%0d data_rvalid", i), data_rvalid_o, tbl[i].e_drv);
            if (tbl[i].e_irv) check($sformatf("row%0d instr_rdata", i), instr_rdata_o, tbl[i].e_rdata);
            if (tbl[i].e_drv) check($sformatf("row%0d data_rdata", i), data_rdata_o, tbl[i].e_rdata);
        end

        // Starvation: data requests every cycle, fetch is forced through on the 5th cycle.
        for (int c = 1; c <= 6; c++) begin
            drive(1'b1, 32'h140, 1'b0, 1'b1, 1'b0, 32'h240, 1'b1, (c > 1), 32'(c), 1'b0);
            check($sformatf("starve c%0d instr_gnt", c), instr_gnt_o, (c == 5));
            check($sformatf("starve c%0d data_gnt", c), data_gnt_o, (c != 5));
            check($sformatf("starve c%0d instr_rvalid", c), instr_rvalid_o, (c == 6));
            check($sformatf("starve c%0d data_rvalid", c), data_rvalid_o, (c >= 2 && c <= 5));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77, 1'b0);
        check("starve drain data_rvalid", data_rvalid_o, 1);

        // Flush: two in-flight fetches are dropped; a later fetch returns normally.
        drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("flush f1 instr_gnt", instr_gnt_o, 1);
        drive(1'b1, 32'h404, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("flush f2 instr_gnt", instr_gnt_o, 1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("flush f3 mem_req", mem_req_o, 0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77, 1'b0);
        check("flush f4 instr_rvalid", instr_rvalid_o, 0);
        check("flush f4 data_rvalid", data_rvalid_o, 0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h88, 1'b0);
        check("flush f5 instr_rvalid", instr_rvalid_o, 0);
        drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("flush f6 instr_gnt", instr_gnt_o, 1);
        check("flush f6 mem_addr", mem_addr_o, 32'h500);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h99, 1'b1);
        check("flush f7 instr_rvalid", instr_rvalid_o, 1);
        check("flush f7 instr_rdata", instr_rdata_o, 32'h99);
        check("flush f7 instr_err", instr_err_o, 1);
        // Flush in the same cycle as a fetch handshake: gnt still given, response dropped.
        drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("flush f8 instr_gnt", instr_gnt_o, 1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAA, 1'b0);
        check("flush f9 instr_rvalid", instr_rvalid_o, 0);
        check("flush f9 data_rvalid", data_rvalid_o, 0);

        // Full FIFO with both sides requesting: nothing issued until a pop has registered.
        drive(1'b1, 32'h700, 1'b0, 1'b1, 1'b0, 32'h800, 1'b1, 1'b0, 32'h0, 1'b0);
        check("full s1 data_gnt", data_gnt_o, 1);
        drive(1'b1, 32'h700, 1'b0, 1'b1, 1'b0, 32'h800, 1'b1, 1'b0, 32'h0, 1'b0);
        check("full s2 data_gnt", data_gnt_o, 1);
        drive(1'b1, 32'h700, 1'b0, 1'b1, 1'b0, 32'h800, 1'b1, 1'b0, 32'h0, 1'b0);
        check("full s3 mem_req", mem_req_o, 0);
        check("full s3 data_gnt", data_gnt_o, 0);
        drive(1'b1, 32'h700, 1'b0, 1'b1, 1'b0, 32'h800, 1'b1, 1'b1, 32'hA1, 1'b0);
        check("full s4 mem_req", mem_req_o, 0);
        check("full s4 data_rvalid", data_rvalid_o, 1);
        drive(1'b1, 32'h700, 1'b0, 1'b1, 1'b0, 32'h800, 1'b1, 1'b0, 32'h0, 1'b0);
        check("full s5 mem_req", mem_req_o, 1);
        check("full s5 instr_gnt", instr_gnt_o, 1);

        // Reset with two transactions outstanding and requests still asserted.
        @(negedge clk);
        rstn = 1'b0;
        mem_rvalid_i = 1'b1;
        #1;
        check("rst mem_req", mem_req_o, 0);
        check("rst instr_gnt", instr_gnt_o, 0);
        check("rst data_gnt", data_gnt_o, 0);
        check("rst instr_rvalid", instr_rvalid_o, 0);
        check("rst data_rvalid", data_rvalid_o, 0);
        idle();
        rstn = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h900, 1'b1, 1'b0, 32'h0, 1'b0);
        check("post-rst r1 data_gnt", data_gnt_o, 1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h904, 1'b1, 1'b0, 32'h0, 1'b0);
        check("post-rst r2 mem_req", mem_req_o, 1);
        check("post-rst r2 data_gnt", data_gnt_o, 1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB1, 1'b0);
        check("post-rst r3 data_rvalid", data_rvalid_o, 1);
        check("post-rst r3 data_rdata", data_rdata_o, 32'hB1);
        check("post-rst r3 instr_rvalid", instr_rvalid_o, 0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB2, 1'b0);
        check("post-rst r4 data_rvalid", data_rvalid_o, 1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
